return_addr_stack: RTL and testbench

//  Return-address stack (RAS) for the MIPS soft core fetch path. Pushes PC+4 on
//  JAL/JALR, pops on JR $ra; top_addr drives data_in of the downstream

---
 rtl/return_addr_stack_if.sv | 24 ++
 rtl/return_addr_stack.sv | 91 +++++++++
 tb/tb_return_addr_stack.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: call/return control and stack status bundle for the return-address stack
interface return_addr_stack_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] top_addr;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, push, pop, pc_in,
        input  top_addr, empty, full, overflow, underflow
    );

    modport slave (
        input  flush, push, pop, pc_in,
        output top_addr, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with saturating count and sticky flags.
// Define RAS_WRAP_EN to let a push while full overwrite the oldest entry; by default it is dropped.
module return_addr_stack #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    return_addr_stack_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     sp, sp_nxt, top_idx, wr_idx;
    logic [AW:0]       count, count_nxt;
    logic              overflow, overflow_nxt, underflow, underflow_nxt;
    logic              we, is_empty, is_full;
    logic [DATA_W-1:0] push_val;

    assign top_idx  = sp - 1'b1;
    assign is_empty = count == '0;
    assign is_full  = count == FULL_CNT;
    assign push_val = bus.pc_in + DATA_W'(4);

    assign bus.top_addr  = is_empty ? '0 : mem[top_idx];
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;

    // Next-state decode in priority order flush > push&pop > push > pop
    always_comb begin
        sp_nxt        = sp;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        we            = 1'b0;
        wr_idx        = sp;
        if (bus.flush) begin
            sp_nxt        = '0;
            count_nxt     = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else if (bus.push && bus.pop && !is_empty) begin
            we     = 1'b1;
            wr_idx = top_idx;
        end else if (bus.push) begin
            if (!is_full) begin
                we        = 1'b1;
                sp_nxt    = sp + 1'b1;
                count_nxt = count + 1'b1;
            end else begin
                overflow_nxt = 1'b1;
`ifdef RAS_WRAP_EN
                we     = 1'b1;
                sp_nxt = sp + 1'b1;
`else
                we     = 1'b0;
`endif
            end
        end else if (bus.pop) begin
            if (!is_empty) begin
                sp_nxt    = sp - 1'b1;
                count_nxt = count - 1'b1;
            end else begin
                underflow_nxt = 1'b1;
            end
        end
    end

    // Pointer, occupancy and sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Entry storage is left unreset; reads are masked while empty
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= push_val;
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: scoreboard bench comparing the RAS against a queue-based stack model
module tb_return_addr_stack;
    typedef struct packed {
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] stk [$];
    bit          m_ovf, m_unf;
    exp_t        sb [$];

    always #5 clk = ~clk;

    return_addr_stack_if #(.DATA_W(32)) bus ();

    return_addr_stack #(.DEPTH(8), .AW(3), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.top   = (stk.size() != 0) ? stk[stk.size() - 1] : 32'h0;
        e.empty = stk.size() == 0;
        e.full  = stk.size() == 8;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_step(input bit fl, input bit ps, input bit pp, input logic [31:0] pc);
        logic [31:0] v;
        v = pc + 32'd4;
        if (fl) begin
            stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (ps && pp && stk.size() != 0) begin
            stk[stk.size() - 1] = v;
        end else if (ps) begin
            if (stk.size() < 8) stk.push_back(v);
            else begin
                m_ovf = 1;
`ifdef RAS_WRAP_EN
                void'(stk.pop_front());
                stk.push_back(v);
`endif
            end
        end else if (pp) begin
            if (stk.size() != 0) void'(stk.pop_back());
            else m_unf = 1;
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_top"}, bus.top_addr, e.top);
        check({tag, "_empty"}, 32'(bus.empty), 32'(e.empty));
        check({tag, "_full"}, 32'(bus.full), 32'(e.full));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(e.ovf));
        check({tag, "_unf"}, 32'(bus.underflow), 32'(e.unf));
    endtask

    task automatic step(input string tag, input bit fl, input bit ps, input bit pp, input logic [31:0] pc);
        bus.flush = fl;
        bus.push  = ps;
        bus.pop   = pp;
        bus.pc_in = pc;
        model_step(fl, ps, pp, pc);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        bus.flush = 0;
        bus.push  = 0;
        bus.pop   = 0;
        compare_outputs(tag);
    endtask

    task automatic reset_check(input string tag);
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        sb.push_back(model_out());
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.flush = 0;
        bus.push  = 0;
        bus.pop   = 0;
        bus.pc_in = '0;
        #2;
        reset_check("rst");
        @(negedge clk);
        rst_n = 1'b1;

        step("t1_push", 0, 1, 0, 32'h0040_0000);
        check("t1_top_const", bus.top_addr, 32'h0040_0004);

        step("t2_flush", 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step("t2_push", 0, 1, 0, 32'(i * 32'h100));
        check("t2_top_const", bus.top_addr, 32'h304);
        for (int i = 0; i < 4; i++) step("t2_pop", 0, 0, 1, 0);
        check("t2_unf_const", 32'(bus.underflow), 32'd1);

        step("t3_flush", 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step("t3_push", 0, 1, 0, 32'(i * 16));
`ifdef RAS_WRAP_EN
        check("t3_top_const", bus.top_addr, 32'h94);
`else
        check("t3_top_const", bus.top_addr, 32'h84);
`endif
        for (int i = 0; i < 8; i++) step("t3_pop", 0, 0, 1, 0);

        step("t4_flush", 1, 0, 0, 0);
        step("t4_push", 0, 1, 0, 32'h100);
        step("t4_pushpop", 0, 1, 1, 32'h500);
        check("t4_top_const", bus.top_addr, 32'h504);
        step("t4_flush2", 1, 0, 0, 0);
        step("t4_pushpop_empty", 0, 1, 1, 32'h500);

        step("t5_flush", 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("t5_push", 0, 1, 0, 32'(32'h1000 + i * 8));
        for (int i = 0; i < 5; i++) step("t5_pop", 0, 0, 1, 0);
        step("t5_flush_push", 1, 1, 0, 32'h777);
        check("t5_empty_const", 32'(bus.empty), 32'd1);

        step("t6_wrap", 0, 1, 0, 32'hFFFF_FFFC);
        check("t6_top_const", bus.top_addr, 32'h0);
        step("t6_push", 0, 1, 0, 32'h2000);
        step("t6_push", 0, 1, 0, 32'h3000);
        bus.push  = 1;
        bus.pc_in = 32'h4000;
        #2;
        rst_n = 1'b0;
        reset_check("t6_async_rst");
        @(negedge clk);
        bus.push = 0;
        rst_n    = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step("rnd", r < 3, (r >= 3 && r < 55) || r >= 85, r >= 55, $urandom & 32'hFFFF_FFFC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
